dequantize_8bit: RTL

//  Widening counterpart of the 9->8 bit requantizer: expands SIZE packed signed 8-bit

---
 rtl/dequant_pkg.sv | 19 +
 rtl/dequant_lane.sv | 76 +++++++
 rtl/dequantize_8bit.sv | 97 +++++++++
 3 files changed

// File: rtl/dequant_pkg.sv
// Shared constants and helpers for the 8-bit dequantizer.
// Provides pixel width, shifted width and saturation bounds.
package dequant_pkg;

  localparam int PIX_W = 8;

  function automatic int w1(input int shift);
    return PIX_W + 1 + ((shift > 0) ? shift : 0);
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/dequant_lane.sv
// One lane: sign-extend and scale by 2^SHIFT, optional bias,
// saturate to OUT_W. Bias port only with DEQUANT_BIAS_EN.
module dequant_lane
  import dequant_pkg::*;
#(
  parameter int SHIFT = 2,
  parameter int OUT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ld1_i,
  input  logic             ld2_i,
  input  logic [PIX_W-1:0] pix_i,
`ifdef DEQUANT_BIAS_EN
  input  logic [OUT_W-1:0] bias_i,
`endif
  output logic [OUT_W-1:0] val_o,
  output logic             sat_o
);

  localparam int W1 = w1(SHIFT);
  localparam int WS = ((W1 > OUT_W) ? W1 : OUT_W) + 1;
  localparam logic signed [WS-1:0] MAXV = WS'(sat_max(OUT_W));
  localparam logic signed [WS-1:0] MINV = WS'(sat_min(OUT_W));

  logic signed [W1-1:0] ext;
  logic signed [W1-1:0] sh_d;
  logic signed [W1-1:0] sh_q;
  logic signed [WS-1:0] sum;
  logic [OUT_W-1:0]     val_d;
  logic [OUT_W-1:0]     val_q;
  logic                 hi;
  logic                 lo;

  assign ext = W1'($signed(pix_i));

  if (SHIFT > 0) begin : g_shl
    assign sh_d = ext <<< SHIFT;
  end else if (SHIFT < 0) begin : g_shr
    assign sh_d = ext >>> (-SHIFT);
  end else begin : g_pass
    assign sh_d = ext;
  end

  // Stage 1: hold the scaled lane value
  always_ff @(posedge clock) begin
    if (reset) sh_q <= '0;
    else if (ld1_i) sh_q <= sh_d;
  end

`ifdef DEQUANT_BIAS_EN
  assign sum = WS'(sh_q) + WS'($signed(bias_i));
`else
  assign sum = WS'(sh_q);
`endif

  assign hi = sum > MAXV;
  assign lo = sum < MINV;

  // Clamp to the output range
  always_comb begin
    val_d = sum[OUT_W-1:0];
    if (hi) val_d = MAXV[OUT_W-1:0];
    else if (lo) val_d = MINV[OUT_W-1:0];
  end

  // Stage 2: hold the saturated lane result
  always_ff @(posedge clock) begin
    if (reset) val_q <= '0;
    else if (ld2_i) val_q <= val_d;
  end

  assign val_o = val_q;
  assign sat_o = hi | lo;

endmodule

// File: rtl/dequantize_8bit.sv
// Widen SIZE signed 8-bit lanes to OUT_W bits with 2^SHIFT scale.
// 2-stage elastic pipe; DEQUANT_BIAS_EN adds a per-lane bias input.
module dequantize_8bit
  import dequant_pkg::*;
#(
  parameter int SHIFT     = 2,
  parameter int SIZE      = 4,
  parameter int OUT_W     = 16,
  parameter int FRAME_LEN = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [PIX_W*SIZE-1:0] pixel_in,
`ifdef DEQUANT_BIAS_EN
  input  logic [OUT_W*SIZE-1:0] bias_in,
`endif
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [OUT_W*SIZE-1:0] pixel_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  sat_flag
);

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  logic            s1_v_q;
  logic            s2_v_q;
  logic            sat_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            en1;
  logic            en2;
  logic            ld1;
  logic            ld2;
  logic            xfer;
  logic            at_last;
  logic [SIZE-1:0] lane_sat;

  assign en2  = !s2_v_q || out_ready;
  assign en1  = !s1_v_q || en2;
  assign ld1  = en1 && in_valid;
  assign ld2  = en2 && s1_v_q;
  assign xfer = s2_v_q && out_ready;

  assign at_last = cnt_q == LAST;
  assign cnt_d   = at_last ? '0 : cnt_q + 1'b1;

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    dequant_lane #(
      .SHIFT (SHIFT),
      .OUT_W (OUT_W)
    ) u_lane (
      .clock (clock),
      .reset (reset),
      .ld1_i (ld1),
      .ld2_i (ld2),
      .pix_i (pixel_in[PIX_W*i +: PIX_W]),
`ifdef DEQUANT_BIAS_EN
      .bias_i(bias_in[OUT_W*i +: OUT_W]),
`endif
      .val_o (pixel_out[OUT_W*i +: OUT_W]),
      .sat_o (lane_sat[i])
    );
  end

  // Stage valids advance when the next stage can take them
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
    end else begin
      if (en1) s1_v_q <= in_valid;
      if (en2) s2_v_q <= s1_v_q;
    end
  end

  // Beat position within the frame, stepped per output transfer
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else if (xfer) cnt_q <= cnt_d;
  end

  // Sticky saturation seen on any beat entering stage 2
  always_ff @(posedge clock) begin
    if (reset) sat_q <= 1'b0;
    else if (ld2 && |lane_sat) sat_q <= 1'b1;
  end

  assign in_ready  = en1;
  assign out_valid = s2_v_q;
  assign out_last  = s2_v_q && at_last;
  assign sat_flag  = sat_q;

endmodule
